mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one 32-bit single-port memory between the core's instruction-fetch port and data port.
- Sits between mips and the memory array, replacing the direct two-port connection.
- Splits 64-bit data accesses into two 32-bit beats.
- Stalls each requester through its abort line until its access completes.

Parameters:
N, 64, core data width (readdata/writedata)
AW, 32, memory address width

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-low
instrreq  in  1  instruction fetch request, held until accepted
instradr  in  32  fetch address, word aligned
instr  out  32  fetched instruction, valid when instrreq=1 and instrabort=0
instrabort  out  1  fetch stall
datareq  in  1  data access request, held until accepted
memwrite  in  2  00 read, 01 word write, 10 doubleword write, 11 doubleword read
dataadr  in  N  data address; bits [AW-1:0] used
writedata  in  N  store data
readdata  out  N  load data, valid when datareq=1 and dataabort=0
dataabort  out  1  data stall
mem_req  out  1  memory beat request
mem_we  out  1  memory beat write enable
mem_adr  out  AW  memory beat address
mem_wdata  out  32  memory beat write data
mem_rdata  in  32  memory beat read data, valid with mem_ready
mem_ready  in  1  beat complete; may assert in the same cycle as mem_req

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - instr, readdata, mem_req, mem_we, mem_adr and mem_wdata are 0.
  - Abort outputs are combinational and still follow their rules during reset.
- States: IDLE, D0, D1, DRESP, I0, IRESP.
- IDLE:
  - datareq has priority: go to D0.
  - Otherwise, if instrreq is high, go to I0.
- D0:
  - mem_req=1.
  - mem_adr = {dataadr[AW-1:3],3'b000} for doubleword accesses, {dataadr[AW-1:2],2'b00} for word accesses.
  - mem_we = (memwrite==01 or 10).
  - mem_wdata = writedata[31:0].
  - On mem_ready:
    - read: capture mem_rdata into readdata[31:0].
    - If doubleword, go to D1; otherwise go to DRESP.
- D1:
  - mem_req=1, mem_adr = beat0 address + 4, mem_wdata = writedata[63:32].
  - On mem_ready: read captures into readdata[63:32]; go to DRESP.
- Word read: readdata[63:32] is cleared to 0 when D0 is entered.
- DRESP: the data response cycle.
  - If instrreq is high, go to I0 (anti-starvation alternation).
  - Otherwise go to IDLE.
- I0:
  - mem_req=1, mem_we=0, mem_adr = {instradr[AW-1:2],2'b00}.
  - On mem_ready, capture instr and go to IRESP.
- IRESP: the fetch response cycle.
  - If datareq is high, go to D0.
  - Otherwise go to IDLE.
- Outside D0/D1/I0: mem_req=0 and mem_we=0. mem_adr and mem_wdata hold.
- Abort rules (combinational):
  - dataabort = datareq & (state != DRESP).
  - instrabort = instrreq & (state != IRESP).
- Requesters hold their request, address, memwrite and writedata stable while abort is high.
- A requester sees completion as the single cycle in which its abort is low with its request high.
- readdata and instr hold their value until the next capture.
- Latency with zero-wait memory (mem_ready tied high), counted from the request cycle in IDLE:
  - word or fetch: abort low in cycle 3.
  - doubleword: abort low in cycle 4.
- Each memory wait cycle adds one cycle per beat.
- Simultaneous datareq and instrreq in IDLE: data is served first, fetch follows directly from DRESP.
- Request dropped mid-access (flush):
  - The current beat(s) still complete, including the second beat of a doubleword write.
  - Then DRESP/IRESP is entered and exited normally; no response is observed.
- Reset mid-access: mem_req drops immediately; a partial doubleword write is allowed.
- Misaligned addresses: low bits are silently masked; no error reporting.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum: IDLE, D0, D1, DRESP, I0, IRESP.
  - memwrite encodings: MW_READ=2'b00, MW_WORD=2'b01, MW_DWORD=2'b10, MR_DWORD=2'b11.
  - constant BEAT_BYTES=4.
- No sub-module: a single FSM with a beat-address mux and capture registers.

Test Plan:
- Zero-wait fetch:
  - Stimulus: instrreq=1, instradr=0x40, memory word 0x40 = 0x20080005.
  - Response: instrabort high for cycles 1-2, low in cycle 3 with instr=0x20080005.
- Doubleword write then read:
  - Stimulus: memwrite=10, dataadr=0x80, writedata=0x1122334455667788.
  - Response: beats write 0x55667788 to 0x80 and 0x11223344 to 0x84.
  - Follow-up: memwrite=11 at 0x80 returns readdata=0x1122334455667788 with dataabort low in cycle 4.
- Simultaneous requests:
  - Stimulus: datareq (word read, 0x100) and instrreq (0x44) both high in the same cycle.
  - Response: data completes first (DRESP); fetch completes 2 cycles later.
  - Check: instrabort stays high throughout the data access.
- Wait states:
  - Stimulus: mem_ready asserted only every 3rd cycle during a doubleword read.
  - Response: mem_adr steps 0x80 then 0x84; dataabort low exactly one cycle after the second ready.
- Flush:
  - Stimulus: datareq dropped during D1 of a doubleword write.
  - Response: both beats still written; FSM returns to IDLE; no response cycle observed.
- Reset mid-I0:
  - Stimulus: reset=0 asserted mid-I0.
  - Response: mem_req=0 immediately, instr=0.
  - Check: after release, a pending instrreq restarts from IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: arbiter FSM states, memwrite encodings and beat size
package mem_arb_pkg;
  typedef enum logic [2:0] {IDLE, D0, D1, DRESP, I0, IRESP} state_t;
  localparam logic [1:0] MW_READ  = 2'b00;
  localparam logic [1:0] MW_WORD  = 2'b01;
  localparam logic [1:0] MW_DWORD = 2'b10;
  localparam logic [1:0] MR_DWORD = 2'b11;
  localparam int BEAT_BYTES = 4;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: core fetch/data ports and 32-bit memory beat bus; slave = arbiter view, master = core+memory view
interface mem_arbiter_if #(parameter int N = 64, parameter int AW = 32);
  logic          instrreq;
  logic [31:0]   instradr;
  logic [31:0]   instr;
  logic          instrabort;
  logic          datareq;
  logic [1:0]    memwrite;
  logic [N-1:0]  dataadr;
  logic [N-1:0]  writedata;
  logic [N-1:0]  readdata;
  logic          dataabort;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  modport slave (
    input  instrreq, instradr, datareq, memwrite, dataadr, writedata, mem_rdata, mem_ready,
    output instr, instrabort, readdata, dataabort, mem_req, mem_we, mem_adr, mem_wdata
  );
  modport master (
    output instrreq, instradr, datareq, memwrite, dataadr, writedata, mem_rdata, mem_ready,
    input  instr, instrabort, readdata, dataabort, mem_req, mem_we, mem_adr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a 32-bit memory between fetch and data ports (clk, reset active-low async, bus: core requests/aborts + memory beats)
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int N  = 64,
  parameter int AW = 32
) (
  input  logic    clk,
  input  logic    reset,
  mem_arbiter_if.slave bus
);
  state_t        state_q, state_d;
  logic [31:0]   instr_q, instr_d;
  logic [N-1:0]  rdata_q, rdata_d;
  logic [AW-1:0] adr_q, adr_d, base_adr;
  logic [31:0]   wdata_q, wdata_d;
  logic          dword, rd, unused;
  assign dword = bus.memwrite[1];
  assign rd = bus.memwrite == MW_READ || bus.memwrite == MR_DWORD;
  assign base_adr = dword ? {bus.dataadr[AW-1:3], 3'b000} : {bus.dataadr[AW-1:2], 2'b00};
  assign unused = ^{bus.dataadr[N-1:AW], bus.dataadr[1:0], bus.instradr[1:0]};
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    rdata_d = rdata_q;
    adr_d = adr_q;
    wdata_d = wdata_q;
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    case (state_q)
      IDLE: state_d = bus.datareq ? D0 : bus.instrreq ? I0 : IDLE;
      D0: begin
        bus.mem_req = 1'b1;
        bus.mem_we = bus.memwrite == MW_WORD || bus.memwrite == MW_DWORD;
        adr_d = base_adr;
        wdata_d = bus.writedata[31:0];
        if (bus.mem_ready) begin
          if (rd) rdata_d[31:0] = bus.mem_rdata;
          state_d = dword ? D1 : DRESP;
        end
      end
      D1: begin
        bus.mem_req = 1'b1;
        bus.mem_we = bus.memwrite == MW_DWORD;
        adr_d = base_adr + AW'(BEAT_BYTES);
        wdata_d = bus.writedata[63:32];
        if (bus.mem_ready) begin
          if (rd) rdata_d[63:32] = bus.mem_rdata;
          state_d = DRESP;
        end
      end
      DRESP: state_d = bus.instrreq ? I0 : IDLE;
      I0: begin
        bus.mem_req = 1'b1;
        adr_d = {bus.instradr[AW-1:2], 2'b00};
        if (bus.mem_ready) begin
          instr_d = bus.mem_rdata;
          state_d = IRESP;
        end
      end
      IRESP: state_d = bus.datareq ? D0 : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == D0 && state_q != D0 && bus.memwrite == MW_READ) rdata_d[N-1:32] = '0;
  end
  assign bus.mem_adr = adr_d;
  assign bus.mem_wdata = wdata_d;
  assign bus.instr = instr_q;
  assign bus.readdata = rdata_q;
  assign bus.dataabort = bus.datareq & (state_q != DRESP);
  assign bus.instrabort = bus.instrreq & (state_q != IRESP);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      rdata_q <= '0;
      adr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
      adr_q <= adr_d;
      wdata_q <= wdata_d;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a transaction-level memory model
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  localparam int N = 64;
  localparam int AW = 32;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  mem_arbiter_if #(.N(N), .AW(AW)) bus();
  mem_arbiter #(.N(N), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {logic [31:0] adr; logic we; logic [31:0] wd; int c;} beat_t;
  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  beat_t beats[$];
  beat_t b_tmp;
  int cyc = 0;
  int mode = 0;
  logic rnd_rdy = 1'b0;
  logic load = 1'b0;
  int total = 0;
  int passed = 0;
  assign bus.mem_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 2) : mode == 2 ? rnd_rdy : 1'b0;
  assign bus.mem_rdata = mem[bus.mem_adr[11:2]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rnd_rdy <= 1'($urandom_range(0, 1));
    if (load) for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
    else if (reset && bus.mem_req && bus.mem_ready) begin
      b_tmp.adr = bus.mem_adr;
      b_tmp.we = bus.mem_we;
      b_tmp.wd = bus.mem_wdata;
      b_tmp.c = cyc;
      beats.push_back(b_tmp);
      if (bus.mem_we) mem[bus.mem_adr[11:2]] <= bus.mem_wdata;
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic data_op(input logic [1:0] op, input logic [31:0] adr, input logic [63:0] wd, input string tag);
    logic dw, we;
    logic [31:0] base;
    logic [9:0] wi;
    int n;
    dw = op[1];
    we = op == MW_WORD || op == MW_DWORD;
    base = dw ? adr & ~32'h7 : adr & ~32'h3;
    wi = base[11:2];
    beats.delete();
    @(posedge clk); #1;
    bus.datareq = 1'b1;
    bus.memwrite = op;
    bus.dataadr = {32'h0, adr};
    bus.writedata = wd;
    n = 1;
    @(negedge clk);
    while (bus.dataabort && n < 80) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done"}, 64'(bus.dataabort), 64'd0);
    if (mode == 0) check({tag, " latency"}, 64'(n), dw ? 64'd4 : 64'd3);
    check({tag, " beats"}, 64'(beats.size()), dw ? 64'd2 : 64'd1);
    for (int i = 0; i < beats.size() && i < 2; i++) begin
      check({tag, " beat adr"}, 64'(beats[i].adr), 64'(base + 32'(4 * i)));
      check({tag, " beat we"}, 64'(beats[i].we), 64'(we));
      if (we) check({tag, " beat wdata"}, 64'(beats[i].wd), i == 0 ? 64'(wd[31:0]) : 64'(wd[63:32]));
    end
    if (beats.size() > 0) check({tag, " resp after last beat"}, 64'(cyc), 64'(beats[beats.size()-1].c + 1));
    if (op == MW_READ) check({tag, " readdata"}, bus.readdata, {32'h0, ref_mem[wi]});
    if (op == MR_DWORD) check({tag, " readdata"}, bus.readdata, {ref_mem[wi + 10'd1], ref_mem[wi]});
    if (we) ref_mem[wi] = wd[31:0];
    if (op == MW_DWORD) ref_mem[wi + 10'd1] = wd[63:32];
    @(posedge clk); #1;
    bus.datareq = 1'b0;
  endtask
  task automatic fetch_op(input logic [31:0] adr, input string tag);
    int n;
    beats.delete();
    @(posedge clk); #1;
    bus.instrreq = 1'b1;
    bus.instradr = adr;
    n = 1;
    @(negedge clk);
    while (bus.instrabort && n < 80) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done"}, 64'(bus.instrabort), 64'd0);
    if (mode == 0) check({tag, " latency"}, 64'(n), 64'd3);
    check({tag, " beats"}, 64'(beats.size()), 64'd1);
    if (beats.size() > 0) begin
      check({tag, " beat adr"}, 64'(beats[0].adr), 64'(adr & ~32'h3));
      check({tag, " beat we"}, 64'(beats[0].we), 64'd0);
      check({tag, " resp after beat"}, 64'(cyc), 64'(beats[0].c + 1));
    end
    check({tag, " instr"}, 64'(bus.instr), 64'(ref_mem[adr[11:2]]));
    @(posedge clk); #1;
    bus.instrreq = 1'b0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, dd, id;
    logic ih;
    logic [63:0] wd;
    bus.instrreq = 1'b0;
    bus.instradr = '0;
    bus.datareq = 1'b0;
    bus.memwrite = MW_READ;
    bus.dataadr = '0;
    bus.writedata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
    ref_mem[10'h10] = 32'h20080005;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    bus.instrreq = 1'b1;
    bus.instradr = 32'h40;
    @(negedge clk);
    check("reset instr", 64'(bus.instr), 64'd0);
    check("reset readdata", bus.readdata, 64'd0);
    check("reset mem_req", 64'(bus.mem_req), 64'd0);
    check("reset mem_we", 64'(bus.mem_we), 64'd0);
    check("reset mem_adr", 64'(bus.mem_adr), 64'd0);
    check("reset mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("reset instrabort", 64'(bus.instrabort), 64'd1);
    check("reset dataabort", 64'(bus.dataabort), 64'd0);
    bus.instrreq = 1'b0;
    reset = 1'b1;
    fetch_op(32'h40, "fetch0");
    check("fetch0 value", 64'(bus.instr), 64'h20080005);
    data_op(MW_DWORD, 32'h80, 64'h1122334455667788, "dwr");
    check("dwr mem lo", 64'(mem[10'h20]), 64'h55667788);
    check("dwr mem hi", 64'(mem[10'h21]), 64'h11223344);
    data_op(MR_DWORD, 32'h80, 64'h0, "drd");
    check("drd value", bus.readdata, 64'h1122334455667788);
    beats.delete();
    @(posedge clk); #1;
    bus.datareq = 1'b1;
    bus.memwrite = MW_READ;
    bus.dataadr = 64'h100;
    bus.instrreq = 1'b1;
    bus.instradr = 32'h44;
    n = 1;
    dd = 0;
    id = 0;
    ih = 1'b1;
    @(negedge clk);
    while (id == 0 && n < 80) begin
      if (dd == 0 && !bus.instrabort) ih = 1'b0;
      if (dd == 0 && !bus.dataabort) begin
        dd = n;
        check("sim readdata", bus.readdata, {32'h0, ref_mem[10'h40]});
      end
      if (!bus.instrabort) id = n;
      if (id == 0) begin
        @(posedge clk); #1;
        if (dd != 0) bus.datareq = 1'b0;
        n++;
        @(negedge clk);
      end
    end
    check("sim data latency", 64'(dd), 64'd3);
    check("sim fetch latency", 64'(id), 64'(dd + 2));
    check("sim instrabort held", 64'(ih), 64'd1);
    check("sim instr", 64'(bus.instr), 64'(ref_mem[10'h11]));
    @(posedge clk); #1;
    bus.instrreq = 1'b0;
    bus.datareq = 1'b0;
    mode = 1;
    data_op(MR_DWORD, 32'h80, 64'h0, "wait drd");
    mode = 0;
    wd = {$urandom, $urandom};
    beats.delete();
    @(posedge clk); #1;
    bus.datareq = 1'b1;
    bus.memwrite = MW_DWORD;
    bus.dataadr = 64'h200;
    bus.writedata = wd;
    @(posedge clk);
    @(posedge clk); #1;
    bus.datareq = 1'b0;
    @(negedge clk);
    check("flush D1 mem_adr", 64'(bus.mem_adr), 64'h204);
    @(negedge clk);
    check("flush no response", 64'(bus.dataabort), 64'd0);
    @(negedge clk);
    check("flush idle mem_req", 64'(bus.mem_req), 64'd0);
    check("flush beats", 64'(beats.size()), 64'd2);
    check("flush mem lo", 64'(mem[10'h80]), 64'(wd[31:0]));
    check("flush mem hi", 64'(mem[10'h81]), 64'(wd[63:32]));
    ref_mem[10'h80] = wd[31:0];
    ref_mem[10'h81] = wd[63:32];
    fetch_op(32'h204, "post flush");
    mode = 3;
    @(posedge clk); #1;
    bus.instrreq = 1'b1;
    bus.instradr = 32'h48;
    @(posedge clk);
    @(negedge clk);
    check("I0 mem_req", 64'(bus.mem_req), 64'd1);
    #1 reset = 1'b0;
    #1;
    check("rst mid mem_req", 64'(bus.mem_req), 64'd0);
    check("rst mid instr", 64'(bus.instr), 64'd0);
    check("rst mid readdata", bus.readdata, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    mode = 0;
    n = 1;
    @(negedge clk);
    while (bus.instrabort && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("rst restart latency", 64'(n), 64'd3);
    check("rst restart instr", 64'(bus.instr), 64'(ref_mem[10'h12]));
    @(posedge clk); #1;
    bus.instrreq = 1'b0;
    for (int k = 0; k < 40; k++) begin
      mode = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) fetch_op($urandom_range(0, 4095), "rnd fetch");
      else data_op(2'($urandom_range(0, 3)), $urandom_range(0, 4095), {$urandom, $urandom}, "rnd data");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
